// File: rtl/i2s_rcvr.sv
// I2S receiver: synchronizes bck/lrck/data into the clk domain and assembles MSB-first
// serial words into DATA_WIDTH-bit parallel samples, one data_out load per channel slot.
module i2s_rcvr #(
    parameter int unsigned DATA_WIDTH  = 24,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  bck,
    input  logic                  lrck,
    input  logic                  data,
    output logic [DATA_WIDTH-1:0] data_out
);

    localparam int unsigned CntW = $clog2(DATA_WIDTH + 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(DATA_WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    logic [SYNC_STAGES-1:0] bck_sync_q, lrck_sync_q, data_sync_q;
    logic                   bck_prev_q, lrck_prev_q;
    logic                   bck_s, lrck_s, data_s;
    logic                   bck_rise, slot_start, shift_en, load;
    logic [DATA_WIDTH-1:0]  shift_q, data_out_q;
    logic [CntW-1:0]        bit_cnt_q;
    state_e                 state_q, state_d;

    assign bck_s  = bck_sync_q[SYNC_STAGES-1];
    assign lrck_s = lrck_sync_q[SYNC_STAGES-1];
    assign data_s = data_sync_q[SYNC_STAGES-1];

    assign bck_rise   = bck_s & ~bck_prev_q;
    assign slot_start = bck_rise & (lrck_s != lrck_prev_q);
    // The bit sampled on the slot-start edge is the previous word's trailing bit; never shifted.
    assign shift_en   = bck_rise & ~slot_start & (state_q == StShift) & (bit_cnt_q < FullCnt);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bck_sync_q  <= '0;
            lrck_sync_q <= '0;
            data_sync_q <= '0;
            bck_prev_q  <= 1'b0;
        end else begin
            bck_sync_q  <= {bck_sync_q[SYNC_STAGES-2:0], bck};
            lrck_sync_q <= {lrck_sync_q[SYNC_STAGES-2:0], lrck};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], data};
            bck_prev_q  <= bck_s;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lrck_prev_q <= 1'b0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            data_out_q  <= '0;
        end else begin
            if (bck_rise) begin
                lrck_prev_q <= lrck_s;
            end
            if (slot_start) begin
                bit_cnt_q <= '0;
                shift_q   <= '0;
            end else if (shift_en) begin
                bit_cnt_q <= bit_cnt_q + CntW'(1);
                shift_q   <= {shift_q[DATA_WIDTH-2:0], data_s};
            end
            if (load) begin
                data_out_q <= shift_q;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Idle doubles as the post-load wait: trailing bits of a long slot are ignored there.
    always_comb begin
        state_d = state_q;
        if (slot_start) begin
            state_d = StShift;
        end else begin
            unique case (state_q)
                StShift: if (shift_en && bit_cnt_q == LastCnt) state_d = StDone;
                StDone:  state_d = StIdle;
                default: ;
            endcase
        end
    end

    always_comb begin
        load = (state_q == StDone);
    end

    assign data_out = data_out_q;

endmodule

// File: tb/tb_i2s_rcvr.sv
// Directed bench for i2s_rcvr: table of slots with hand-computed results, plus latency,
// mid-slot reset and a randomized scoreboard run.
module tb_i2s_rcvr;

    localparam int unsigned DW = 24;
    localparam int unsigned SS = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          bck = 1'b0;
    logic          lrck = 1'b0;
    logic          data = 1'b0;
    logic [DW-1:0] data_out;

    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0] prev_out = '0;
    logic [DW-1:0] seen_q[$];
    logic [DW-1:0] exp_q[$];

    typedef struct {
        logic          lr;
        logic [DW-1:0] word;
        int            nbck;
        logic          fill;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t vecs[10];

    i2s_rcvr #(.DATA_WIDTH(DW), .SYNC_STAGES(SS)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bck      (bck),
        .lrck     (lrck),
        .data     (data),
        .data_out (data_out)
    );

    always #20 clk = ~clk;

    // Records every distinct value data_out takes on.
    always @(negedge clk) begin
        if (data_out !== prev_out) seen_q.push_back(data_out);
        prev_out <= data_out;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bck_cycle(input logic lr, input logic d);
        bck  = 1'b0;
        lrck = lr;
        data = d;
        #40;
        bck = 1'b1;
        #40;
    endtask

    // Cycle 0 carries the new lrck and a dummy trailing bit; word bits follow MSB first.
    task automatic send_slot(input logic lr, input logic [DW-1:0] w, input int nbck,
                             input logic fill);
        for (int c = 0; c < nbck; c++) begin
            if (c == 0) bck_cycle(lr, 1'b1);
            else if (c <= DW) bck_cycle(lr, w[DW-c]);
            else bck_cycle(lr, fill);
        end
    endtask

    task automatic gap();
        bck = 1'b0;
        #200;
    endtask

    initial begin
        logic [DW-1:0] last_exp;
        logic [DW-1:0] w;
        logic          lr;

        vecs[0] = '{lr: 1'b1, word: 24'hA5C3F0, nbck: 25, fill: 1'b0, exp: 24'hA5C3F0};
        vecs[1] = '{lr: 1'b0, word: 24'h123456, nbck: 25, fill: 1'b1, exp: 24'h123456};
        vecs[2] = '{lr: 1'b1, word: 24'hFEDCBA, nbck: 25, fill: 1'b0, exp: 24'hFEDCBA};
        vecs[3] = '{lr: 1'b0, word: 24'h000001, nbck: 33, fill: 1'b1, exp: 24'h000001};
        vecs[4] = '{lr: 1'b1, word: 24'h800000, nbck: 33, fill: 1'b1, exp: 24'h800000};
        vecs[5] = '{lr: 1'b0, word: 24'hABCDEF, nbck: 11, fill: 1'b1, exp: 24'h800000};
        vecs[6] = '{lr: 1'b1, word: 24'h0F0F0F, nbck: 25, fill: 1'b0, exp: 24'h0F0F0F};
        vecs[7] = '{lr: 1'b0, word: 24'hFFFFFF, nbck: 25, fill: 1'b0, exp: 24'hFFFFFF};
        vecs[8] = '{lr: 1'b1, word: 24'h000000, nbck: 25, fill: 1'b1, exp: 24'h000000};
        vecs[9] = '{lr: 1'b0, word: 24'h13579B, nbck: 25, fill: 1'b0, exp: 24'h13579B};

        // Reset held while the bus runs.
        @(posedge clk);
        #7;
        send_slot(1'b1, 24'h5A5A5A, 25, 1'b0);
        send_slot(1'b0, 24'hC3C3C3, 25, 1'b0);
        gap();
        check("reset_hold", 32'(data_out), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #7;
        check("after_release", 32'(data_out), 32'h0);

        last_exp = '0;
        for (int i = 0; i < 10; i++) begin
            seen_q.delete();
            send_slot(vecs[i].lr, vecs[i].word, vecs[i].nbck, vecs[i].fill);
            gap();
            check($sformatf("vec%0d_data", i), 32'(data_out), 32'(vecs[i].exp));
            check($sformatf("vec%0d_loads", i), 32'(seen_q.size()),
                  (vecs[i].exp != last_exp) ? 32'd1 : 32'd0);
            last_exp = vecs[i].exp;
        end

        // Latency: new value exactly SS+2 clk edges after the LSB's bck rise.
        w = 24'h5A3C0F;
        send_slot(1'b1, w, DW, 1'b0);
        bck  = 1'b0;
        data = w[0];
        #40;
        bck = 1'b1;
        repeat (SS + 1) @(posedge clk);
        #1;
        check("latency_early", 32'(data_out), 32'h13579B);
        @(posedge clk);
        #1;
        check("latency_exact", 32'(data_out), 32'(w));
        #6;
        gap();

        // Reset in the middle of a slot.
        w = 24'h2468AC;
        seen_q.delete();
        send_slot(1'b0, w, 11, 1'b0);
        bck = 1'b0;
        #5;
        reset_n = 1'b0;
        #1;
        check("midreset_async", 32'(data_out), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #7;
        for (int c = 11; c <= DW; c++) bck_cycle(1'b0, w[DW-c]);
        gap();
        check("midreset_partial", 32'(data_out), 32'h0);
        check("midreset_loads", 32'(seen_q.size()), 32'd1);
        send_slot(1'b1, 24'h0A0B0C, 25, 1'b0);
        gap();
        check("midreset_resume", 32'(data_out), 32'h0A0B0C);

        // Back-to-back random slots against a scoreboard.
        seen_q.delete();
        last_exp = 24'h0A0B0C;
        lr = 1'b1;
        for (int i = 0; i < 100; i++) begin
            w = 24'($urandom());
            if (w == last_exp) w = w ^ 24'h1;
            last_exp = w;
            lr = ~lr;
            exp_q.push_back(w);
            send_slot(lr, w, 25, 1'b0);
        end
        gap();
        check("rand_loads", 32'(seen_q.size()), 32'd100);
        for (int i = 0; i < 100 && i < seen_q.size(); i++) begin
            check($sformatf("rand%0d", i), 32'(seen_q[i]), 32'(exp_q[i]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/i2s_rcvr.md
Name: i2s_rcvr

Overview:
- I2S serial audio receiver; converts the standard I2S stream (bck, lrck, data) into 24-bit parallel samples.
- Works in the system clock domain (clk). bck, lrck and data are asynchronous inputs: they are synchronized, and bck edges are detected in the clk domain.
- Sits between an external I2S source (ADC/codec) and downstream audio processing.
- Left and right samples both go to one output register, updated once per channel slot.

Parameters:
- DATA_WIDTH, 24, bits per sample and width of data_out.
- SYNC_STAGES, 2, flip-flop stages on each asynchronous input (bck, lrck, data); minimum 2.

Ports:
- clk  input  1  system clock, nominal 24 MHz; all logic on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- bck  input  1  I2S bit clock, nominal 12 MHz, asynchronous to clk.
- lrck  input  1  I2S word select; 0 = left, 1 = right; changes on bck falling edge.
- data  input  1  I2S serial data; changes on bck falling edge; MSB first.
- data_out  output  DATA_WIDTH  last fully received sample.

Behaviour:
- Clocking: single clock, clk. reset_n asserts asynchronously and is released synchronously by the system.
- Clock ratio: clk must be at least 2x bck, and each bck high and low phase must last at least one clk period.
- Synchronization: bck, lrck and data each pass through SYNC_STAGES flops. A further register holds the previous synchronized bck.
- Edge detect: a bck rising edge (bck_rise) is a one-clk pulse when synced bck = 1 and previous synced bck = 0. All sampling below happens only on bck_rise cycles.
- Word-select detection: on each bck_rise, compare synced lrck with lrck_prev, then store it in lrck_prev.
  - A difference marks a slot start.
  - The data bit on that same bck_rise is the previous word's trailing bit (I2S one-bit delay). It is discarded.
  - bit_cnt <= 0 and the shift register is cleared.
- Shifting: on each following bck_rise with bit_cnt < DATA_WIDTH:
  - shift_reg <= {shift_reg[DATA_WIDTH-2:0], data_sync};
  - bit_cnt increments.
- Capture: on the clk cycle after the bck_rise that shifts in the DATA_WIDTH-th bit (the LSB), data_out <= shift_reg (registered, one load).
- Overall latency: data_out changes SYNC_STAGES+2 clk cycles after the LSB is stable at the data pin at the bck rising edge.
- Long slot: bits after the DATA_WIDTH-th and before the next lrck change are ignored. bit_cnt saturates at DATA_WIDTH, and data_out is not reloaded.
- Short slot: if lrck changes before DATA_WIDTH bits arrive, the partial word is discarded and data_out keeps its previous value. The new slot starts as normal.
- State machine, 3 states:
  - IDLE: after reset; wait for an lrck change.
  - SHIFT: count bits.
  - DONE: DATA_WIDTH bits received; one-cycle load of data_out, then wait for the next lrck change.
  - An lrck change in any state goes to SHIFT with bit_cnt = 0.
- Reset values:
  - data_out = 0, shift_reg = 0, bit_cnt = 0.
  - lrck_prev = 0, all sync flops = 0, state = IDLE.
  - Because lrck_prev resets to 0, lrck = 1 at the first sampled bck_rise after reset counts as a slot start.
- Reset mid-word: the partial word is lost and data_out = 0 immediately. Capture resumes at the next lrck change.

Test Plan:
- Reset: hold reset_n = 0 with bck toggling -> data_out = 0. Assert reset_n mid-slot -> data_out = 0 asynchronously, and the partial word is never output.
- Single word: toggle lrck 0->1 at a bck falling edge, then send 24 bits of 0xA5C3F0 MSB first -> data_out = 0xA5C3F0 within SYNC_STAGES+2 clk cycles after the LSB is stable.
- Alternating channels: send left 0x123456, then right 0xFEDCBA, with 25 bck per slot -> data_out = 0x123456, then 0xFEDCBA, each loaded exactly once.
- Long slot: send 32 bck per slot, with bits 25-32 = 1 and word 0x000001 -> data_out = 0x000001; trailing bits ignored.
- Short slot: toggle lrck after 10 bits -> data_out keeps its prior value; the next full word is then received correctly.
- Random: 100 slots of random 24-bit words at clk 24 MHz and bck 12 MHz -> every data_out load matches the scoreboard.
